lane_score_engine: RTL and testbench

LANE_SCORE_ENGINE -- requirements
Module: lane_score_engine

---
 rtl/lane_score_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_lane_score_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_score_engine.sv
// Rhythm-game lane scorer.
// Raw buttons are synchronised and debounced per lane. Each note row opens a
// hit window, and the scorer awards a hit or a miss for it. Hits add
// combo-weighted points to a saturating BCD score.
//
// Handshake: note_valid is a one-cycle strobe with no ready or back-pressure.
// note_lanes is sampled only in a cycle where note_valid=1. hit and miss are
// one-cycle result pulses. They appear the cycle after the deciding cycle,
// together with the updated score_bcd and combo.
module lane_score_engine #(
    parameter int LANES           = 5,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WINDOW          = 8,
    parameter int SCORE_DIGITS    = 4
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic [LANES-1:0]              buttons,
    input  logic                          note_valid,
    input  logic [LANES-1:0]              note_lanes,
    output logic [LANES-1:0]              button_debounced,
    output logic                          hit,
    output logic                          miss,
    output logic [4*SCORE_DIGITS-1:0]     score_bcd,
    output logic [7:0]                    combo,
    output logic                          overflow,
    output logic                          dbg_state,
    output logic [$clog2(WINDOW+1)-1:0]   dbg_window
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW);
    localparam logic [4*SCORE_DIGITS-1:0] NINES = {SCORE_DIGITS{4'h9}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [LANES-1:0] sync1_q;
    logic [LANES-1:0] sync2_q;
    logic [LANES-1:0] deb_q;
    logic [LANES-1:0] deb_prev_q;
    logic [CNT_W-1:0] stab_q [LANES];
    logic [LANES-1:0] press;

    // Two-flop synchroniser, then per-lane stability counter; a lane only
    // flips after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                stab_q[i] <= '0;
            end
        end else begin
            sync1_q    <= buttons;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < LANES; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (stab_q[i] == CNT_LAST) begin
                        deb_q[i]  <= sync2_q[i];
                        stab_q[i] <= '0;
                    end else begin
                        stab_q[i] <= stab_q[i] + CNT_W'(1);
                    end
                end else begin
                    stab_q[i] <= '0;
                end
            end
        end
    end

    // Press event: rising edge of any debounced lane.
    assign press = deb_q & ~deb_prev_q;

    // ------------------------------------------------------------------
    // Note FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [LANES-1:0] target_q, target_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             dec_hit;
    logic             dec_miss;

    // State, target and window registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            win_q    <= win_d;
        end
    end

    // Next-state and decision logic. Priority in WAIT is wrong-lane press,
    // then exact-match hit, then preemption by a new note, then timeout.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        win_d    = win_q;
        dec_hit  = 1'b0;
        dec_miss = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (note_valid && (note_lanes != '0)) begin
                    target_d = note_lanes;
                    win_d    = WIN_LOAD;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((press & ~target_q) != '0) begin
                    dec_miss = 1'b1;
                    state_d  = S_IDLE;
                    target_d = '0;
                    win_d    = '0;
                end else if ((press != '0) && (deb_q == target_q)) begin
                    dec_hit  = 1'b1;
                    state_d  = S_IDLE;
                    target_d = '0;
                    win_d    = '0;
                end else if (note_valid) begin
                    dec_miss = 1'b1;
                    if (note_lanes != '0) begin
                        target_d = note_lanes;
                        win_d    = WIN_LOAD;
                    end else begin
                        state_d  = S_IDLE;
                        target_d = '0;
                        win_d    = '0;
                    end
                end else if (win_q == '0) begin
                    dec_miss = 1'b1;
                    state_d  = S_IDLE;
                    target_d = '0;
                end else begin
                    win_d = win_q - WIN_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                target_d = '0;
                win_d    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoring
    // ------------------------------------------------------------------
    logic [4*SCORE_DIGITS-1:0] score_q;
    logic [4*SCORE_DIGITS-1:0] sum_bcd;
    logic [7:0]                combo_q;
    logic                      ovf_q;
    logic                      hit_q;
    logic                      miss_q;
    logic [2:0]                points;
    logic [4:0]                dsum;
    logic                      bcd_carry;

    // Combo-weighted points and a ripple decimal add; a carry out of the
    // top digit means the score has run past all-nines.
    always_comb begin
        points    = 3'd1;
        dsum      = '0;
        bcd_carry = 1'b0;
        sum_bcd   = '0;
        if (combo_q >= 8'd8) begin
            points = 3'd4;
        end else if (combo_q >= 8'd4) begin
            points = 3'd2;
        end
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            dsum = {1'b0, score_q[4*d +: 4]} + {4'b0, bcd_carry}
                 + ((d == 0) ? {2'b0, points} : 5'd0);
            if (dsum > 5'd9) begin
                dsum      = dsum - 5'd10;
                bcd_carry = 1'b1;
            end else begin
                bcd_carry = 1'b0;
            end
            sum_bcd[4*d +: 4] = dsum[3:0];
        end
    end

    // Result pulses, score, combo and sticky overflow all update on the
    // edge that closes the deciding cycle.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= '0;
            combo_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            hit_q  <= dec_hit;
            miss_q <= dec_miss;
            if (dec_hit) begin
                if (bcd_carry) begin
                    score_q <= NINES;
                    ovf_q   <= 1'b1;
                end else begin
                    score_q <= sum_bcd;
                end
                if (combo_q != 8'hFF) begin
                    combo_q <= combo_q + 8'd1;
                end
            end else if (dec_miss) begin
                combo_q <= '0;
            end
        end
    end

    assign button_debounced = deb_q;
    assign hit              = hit_q;
    assign miss             = miss_q;
    assign score_bcd        = score_q;
    assign combo            = combo_q;
    assign overflow         = ovf_q;
    assign dbg_state        = state_q;
    assign dbg_window       = win_q;

endmodule

// File: tb/tb_lane_score_engine.sv
// Bench for lane_score_engine.
// Instance A uses the default parameters and exercises debounce timing,
// preemption and the mid-window clear. Instance B uses a short debounce and
// two score digits so that scoring and saturation run quickly.
module tb_lane_score_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults
  logic        a_clear;
  logic [4:0]  a_buttons;
  logic        a_note_valid;
  logic [4:0]  a_note_lanes;
  logic [4:0]  a_deb;
  logic        a_hit;
  logic        a_miss;
  logic [15:0] a_score;
  logic [7:0]  a_combo;
  logic        a_ovf;
  logic        a_state;
  logic [3:0]  a_win;

  // Instance B: fast debounce, two-digit score
  logic        b_clear;
  logic [4:0]  b_buttons;
  logic        b_note_valid;
  logic [4:0]  b_note_lanes;
  logic [4:0]  b_deb;
  logic        b_hit;
  logic        b_miss;
  logic [7:0]  b_score;
  logic [7:0]  b_combo;
  logic        b_ovf;
  logic        b_state;
  logic [3:0]  b_win;

  lane_score_engine u_a (
    .clk(clk), .clear(a_clear), .buttons(a_buttons), .note_valid(a_note_valid),
    .note_lanes(a_note_lanes), .button_debounced(a_deb), .hit(a_hit), .miss(a_miss),
    .score_bcd(a_score), .combo(a_combo), .overflow(a_ovf),
    .dbg_state(a_state), .dbg_window(a_win)
  );

  lane_score_engine #(
    .LANES(5), .DEBOUNCE_CYCLES(2), .WINDOW(8), .SCORE_DIGITS(2)
  ) u_b (
    .clk(clk), .clear(b_clear), .buttons(b_buttons), .note_valid(b_note_valid),
    .note_lanes(b_note_lanes), .button_debounced(b_deb), .hit(b_hit), .miss(b_miss),
    .score_bcd(b_score), .combo(b_combo), .overflow(b_ovf),
    .dbg_state(b_state), .dbg_window(b_win)
  );

  typedef struct {
    logic [4:0] note;
    logic [4:0] press;
    logic       exp_hit;
    logic [7:0] exp_combo;
    logic [7:0] exp_score;
    int         exp_lat;
  } vec_t;

  vec_t tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // One note on instance B: present it, hold the press pattern, wait for
  // the result pulse, check it and its side effects, then release.
  task automatic b_play(input string name, input logic [4:0] note, input logic [4:0] press,
                        input logic exp_hit, input logic [7:0] exp_combo,
                        input logic [7:0] exp_score, input logic exp_ovf, input int exp_lat);
    int lat;
    lat = 0;
    b_note_lanes = note;
    b_note_valid = 1'b1;
    step();
    b_note_valid = 1'b0;
    b_note_lanes = '0;
    b_buttons    = press;
    for (int i = 0; i < 30 && lat == 0; i++) begin
      step();
      if (b_hit || b_miss) lat = i + 1;
    end
    chk($sformatf("%s_latency", name), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s_hit", name), 32'(b_hit), 32'(exp_hit));
    chk($sformatf("%s_miss", name), 32'(b_miss), 32'(!exp_hit));
    chk($sformatf("%s_combo", name), 32'(b_combo), 32'(exp_combo));
    chk($sformatf("%s_score", name), 32'(b_score), 32'(exp_score));
    chk($sformatf("%s_ovf", name), 32'(b_ovf), 32'(exp_ovf));
    step();
    chk($sformatf("%s_pulse_end", name), 32'(b_hit | b_miss), 32'(0));
    b_buttons = '0;
    repeat (6) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seg[7];
    int sc_m;
    int combo_m;
    int pts;
    logic ovf_m;
    logic bounce_bad;
    logic pulse_seen;
    int rise_at;

    tbl[0]  = '{5'b00101, 5'b00101, 1'b1, 8'd1, 8'h01, 5};
    tbl[1]  = '{5'b00001, 5'b00000, 1'b0, 8'd0, 8'h01, 9};
    tbl[2]  = '{5'b00010, 5'b00010, 1'b1, 8'd1, 8'h02, 5};
    tbl[3]  = '{5'b00010, 5'b00010, 1'b1, 8'd2, 8'h03, 5};
    tbl[4]  = '{5'b00010, 5'b00010, 1'b1, 8'd3, 8'h04, 5};
    tbl[5]  = '{5'b00010, 5'b00010, 1'b1, 8'd4, 8'h05, 5};
    tbl[6]  = '{5'b00010, 5'b00010, 1'b1, 8'd5, 8'h07, 5};
    tbl[7]  = '{5'b00010, 5'b00010, 1'b1, 8'd6, 8'h09, 5};
    tbl[8]  = '{5'b00010, 5'b01000, 1'b0, 8'd0, 8'h09, 5};
    tbl[9]  = '{5'b00011, 5'b00001, 1'b0, 8'd0, 8'h09, 9};
    tbl[10] = '{5'b00001, 5'b00011, 1'b0, 8'd0, 8'h09, 5};
    tbl[11] = '{5'b10000, 5'b10000, 1'b1, 8'd1, 8'h10, 5};

    // Clock/reset
    a_clear = 1'b1; a_buttons = '0; a_note_valid = 1'b0; a_note_lanes = '0;
    b_clear = 1'b1; b_buttons = '0; b_note_valid = 1'b0; b_note_lanes = '0;
    step();
    step();
    chk("rst_deb", 32'(a_deb), 32'(0));
    chk("rst_hit_miss", 32'({a_hit, a_miss}), 32'(0));
    chk("rst_score", 32'(a_score), 32'(0));
    chk("rst_combo", 32'(a_combo), 32'(0));
    chk("rst_ovf", 32'(a_ovf), 32'(0));
    chk("rst_state", 32'(a_state), 32'(0));
    chk("rst_win", 32'(a_win), 32'(0));
    a_clear = 1'b0;
    b_clear = 1'b0;
    step();

    // Debounce: lane 0 bounces every 5 cycles, then is held high.
    bounce_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a_buttons = (k % 2 == 0) ? 5'b00001 : 5'b00000;
      repeat (5) begin
        step();
        if (a_deb != '0) bounce_bad = 1'b1;
      end
    end
    chk("deb_during_bounce", 32'(bounce_bad), 32'(0));
    a_buttons = 5'b00001;
    rise_at = 0;
    for (int n = 1; n <= 40 && rise_at == 0; n++) begin
      step();
      if (a_deb[0]) rise_at = n;
    end
    chk("deb_latency", 32'(rise_at), 32'(18));
    chk("deb_value", 32'(a_deb), 32'(5'b00001));

    // Table-driven scoring on instance B
    for (int v = 0; v < 12; v++) begin
      b_play($sformatf("vec%0d", v), tbl[v].note, tbl[v].press, tbl[v].exp_hit,
             tbl[v].exp_combo, tbl[v].exp_score, 1'b0, tbl[v].exp_lat);
    end

    // Clear B from a non-zero score/combo
    b_clear = 1'b1;
    #1;
    chk("b_clear_score", 32'(b_score), 32'(0));
    chk("b_clear_combo", 32'(b_combo), 32'(0));
    step();
    b_clear = 1'b0;
    step();

    // Saturation: segments of hits separated by misses bring the score to
    // 98 with combo 9, then two more hits run into the ceiling.
    seg = '{9, 9, 9, 9, 9, 2, 11};
    sc_m = 0; combo_m = 0; ovf_m = 1'b0;
    for (int s = 0; s < 7; s++) begin
      for (int h = 0; h < seg[s]; h++) begin
        pts = (combo_m < 4) ? 1 : ((combo_m < 8) ? 2 : 4);
        sc_m += pts;
        if (sc_m > 99) begin
          sc_m = 99;
          ovf_m = 1'b1;
        end
        combo_m = (combo_m == 255) ? 255 : combo_m + 1;
        b_play($sformatf("sat_s%0d_h%0d", s, h), 5'b00100, 5'b00100, 1'b1,
               8'(combo_m), to_bcd(sc_m), ovf_m, 5);
      end
      if (s < 6) begin
        combo_m = 0;
        b_play($sformatf("sat_s%0d_miss", s), 5'b00001, 5'b00010, 1'b0,
               8'd0, to_bcd(sc_m), ovf_m, 5);
      end
    end
    b_clear = 1'b1;
    #1;
    chk("b_clear_ovf", 32'(b_ovf), 32'(0));
    chk("b_clear_score2", 32'(b_score), 32'(0));
    step();
    b_clear = 1'b0;

    // Preemption on instance A, then clear in the middle of the window.
    a_note_lanes = 5'b00010;
    a_note_valid = 1'b1;
    step();
    a_note_valid = 1'b0;
    chk("pre_state_wait", 32'(a_state), 32'(1));
    chk("pre_win_load", 32'(a_win), 32'(8));
    step();
    step();
    chk("pre_win_dec", 32'(a_win), 32'(6));
    a_note_lanes = 5'b00100;
    a_note_valid = 1'b1;
    step();
    a_note_valid = 1'b0;
    a_note_lanes = '0;
    chk("pre_miss", 32'(a_miss), 32'(1));
    chk("pre_no_hit", 32'(a_hit), 32'(0));
    chk("pre_state", 32'(a_state), 32'(1));
    chk("pre_win_reload", 32'(a_win), 32'(8));
    step();
    chk("pre_miss_end", 32'(a_miss), 32'(0));
    chk("pre_win_next", 32'(a_win), 32'(7));
    step();
    a_clear = 1'b1;
    #1;
    chk("mid_clear_state", 32'(a_state), 32'(0));
    chk("mid_clear_win", 32'(a_win), 32'(0));
    chk("mid_clear_deb", 32'(a_deb), 32'(0));
    chk("mid_clear_outs", 32'({a_hit, a_miss, a_ovf}), 32'(0));
    chk("mid_clear_score", 32'({a_score, a_combo}), 32'(0));
    step();
    step();
    a_clear = 1'b0;
    pulse_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_hit || a_miss) pulse_seen = 1'b1;
    end
    chk("mid_clear_no_pulse", 32'(pulse_seen), 32'(0));
    chk("mid_clear_idle", 32'(a_state), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
